// File: rtl/gate_checker_pkg.sv
// rtl/gate_checker_pkg.sv - shared state encoding and truth-table constants for gate_checker
package gate_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit i is the expected gate output for input vector i = {a,b}
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_XNOR  = 4'b1001;
  localparam logic [3:0] TT_NOT_A = 4'b0011;

endpackage

// File: rtl/gate_checker_sync2.sv
// rtl/gate_checker_sync2.sv - two-flop synchroniser with asynchronous reset to 0
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gate_checker.sv
// rtl/gate_checker.sv - walks a two-input gate through all four vectors and checks its output
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int unsigned DWELL  = 12000000,
  parameter int unsigned SETTLE = 4,
  parameter logic [3:0]  TRUTH  = 4'b1110,
  parameter int unsigned CW     = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);

  localparam logic [CW-1:0] SAMPLE_AT = CW'(SETTLE - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    vec_q, vec_d;
  logic [1:0]    ab_q, ab_d;
  logic [3:0]    fail_q, fail_d;
  logic          pass_q, pass_d;
  logic          start_q;
  logic          start_rise;
  logic          y_s;

  sync2 u_sync_y (
    .clk (clk),
    .rst (rst),
    .d_i (y_in),
    .q_o (y_s)
  );

  assign start_rise = start & ~start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      ab_q    <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      ab_q    <= ab_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    ab_d    = ab_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d = RUN;
          cnt_d   = '0;
          vec_d   = 2'd0;
          ab_d    = 2'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // The synchroniser delay is covered because SETTLE is at least 3
        if (cnt_q == SAMPLE_AT) begin
          fail_d[vec_q] = (y_s != TRUTH[vec_q]);
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (vec_q == 2'd3) begin
            state_d = DONE;
            ab_d    = 2'd0;
            pass_d  = (fail_d == 4'd0);
          end else begin
            vec_d = vec_q + 2'd1;
            ab_d  = vec_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_out    = ab_q[1];
  assign b_out    = ab_q[0];
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign fail_vec = fail_q;

endmodule
